// File: rtl/bnn_pkg.sv
// Shared definitions for the binary/unary encoder blocks: placement modes,
// FSM state encoding and count saturation.
package bnn_pkg;

  localparam logic MODE_THERMO = 1'b0;
  localparam logic MODE_SPREAD = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Clamp a requested count to the frame length so it can never wrap.
  function automatic int unsigned sat_count(input int unsigned count,
                                            input int unsigned limit);
    return (count > limit) ? limit : count;
  endfunction

endpackage

// File: rtl/unary_bit_gen.sv
// Combinational bit generator: derives the current frame bit and the next
// spread accumulator from the registered frame state.
module unary_bit_gen
  import bnn_pkg::*;
#(
  parameter int FRAME_BITS = 8
) (
  input  logic [$clog2(FRAME_BITS):0]   n,
  input  logic [$clog2(FRAME_BITS)-1:0] idx,
  input  logic [$clog2(FRAME_BITS):0]   acc,
  input  logic                          mode,
  output logic                          out_bit,
  output logic [$clog2(FRAME_BITS):0]   acc_next
);

  localparam int NW = $clog2(FRAME_BITS) + 1;
  localparam logic [NW-1:0] FRAME = NW'(FRAME_BITS);

  // acc < FRAME_BITS and n <= FRAME_BITS, so s fits in NW bits.
  logic [NW-1:0] s;

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    s        = acc + n;
    out_bit  = 1'b0;
    acc_next = acc;
    if (mode == MODE_SPREAD) begin
      out_bit  = (s >= FRAME);
      acc_next = out_bit ? (s - FRAME) : s;
    end else begin
      out_bit  = ({1'b0, idx} < n);
    end
  end

endmodule

// File: rtl/unary_frame_encoder.sv
// Count-to-bitstream encoder: accepts a count, emits a FRAME_BITS-long frame
// holding min(count, FRAME_BITS) ones, thermometer or evenly spread.
module unary_frame_encoder
  import bnn_pkg::*;
#(
  parameter int FRAME_BITS   = 8,
  parameter int COUNTER_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COUNTER_BITS-1:0] in_count,
  input  logic                    in_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_bit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int IW = $clog2(FRAME_BITS);
  localparam int NW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BITS - 1);

  state_t        state;
  state_t        state_next;
  logic [NW-1:0] n;
  logic [NW-1:0] acc;
  logic [NW-1:0] acc_next;
  logic [NW-1:0] n_in;
  logic [IW-1:0] idx;
  logic          mode;
  logic          gen_bit;
  logic          accept;
  logic          advance;

  assign n_in    = NW'(sat_count(32'(in_count), unsigned'(FRAME_BITS)));
  assign accept  = in_valid && in_ready;
  assign advance = out_valid && out_ready;

  unary_bit_gen #(
    .FRAME_BITS(FRAME_BITS)
  ) u_bit_gen (
    .n       (n),
    .idx     (idx),
    .acc     (acc),
    .mode    (mode),
    .out_bit (gen_bit),
    .acc_next(acc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_EMIT;
      ST_EMIT: if (advance && out_last) state_next = accept ? ST_EMIT : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_EMIT);
    out_last  = out_valid && (idx == LAST_IDX);
    in_ready  = (state == ST_IDLE) || (out_last && out_ready);
    // Gating keeps the bit quiet in IDLE, where n may still hold the old frame.
    out_bit   = out_valid && gen_bit;
  end

  // A new request on the final beat takes priority, giving bubble-free frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n    <= '0;
      acc  <= '0;
      idx  <= '0;
      mode <= MODE_THERMO;
    end else if (accept) begin
      n    <= n_in;
      acc  <= '0;
      idx  <= '0;
      mode <= in_mode;
    end else if (advance) begin
      idx  <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      acc  <= acc_next;
    end
  end

endmodule

// File: tb/tb_unary_frame_encoder.sv
// Scoreboard bench for unary_frame_encoder: requests push expected frames
// from an arithmetic model; a monitor pops and compares every consumed beat.
module tb_unary_frame_encoder;

  localparam int FB = 8;
  localparam int CB = 4;

  typedef struct {
    bit b;
    bit last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CB-1:0] in_count = '0;
  logic          in_mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_bit;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;

  int    checks = 0;
  int    errors = 0;
  bit    rdy_random = 1'b0;
  beat_t exp_q[$];
  int    ones_q[$];

  unary_frame_encoder #(
    .FRAME_BITS  (FB),
    .COUNTER_BITS(CB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_count (in_count),
    .in_mode  (in_mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: ones count saturates; spread bit i is set when floor(i*n/FB)
  // steps up between positions i and i+1.
  task automatic push_frame(input int cnt, input bit md);
    int    n;
    beat_t e;
    n = (cnt > FB) ? FB : cnt;
    for (int i = 0; i < FB; i++) begin
      if (md) e.b = (((i + 1) * n) / FB - (i * n) / FB) != 0;
      else    e.b = (i < n);
      e.last = (i == FB - 1);
      exp_q.push_back(e);
    end
    ones_q.push_back(n);
  endtask

  // Request monitor: an accepted request produces one expected frame.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) push_frame(int'(in_count), in_mode);
  end

  // Output monitor: compares consumed beats and checks stall stability.
  bit stalled = 1'b0;
  bit held_bit, held_last;
  int ones = 0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stalled = 1'b0;
      ones    = 0;
    end else begin
      if (stalled && out_valid) begin
        check("stall_bit", int'(out_bit), int'(held_bit));
        check("stall_last", int'(out_last), int'(held_last));
      end
      stalled   = out_valid && !out_ready;
      held_bit  = out_bit;
      held_last = out_last;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_bit", int'(out_bit), int'(e.b));
          check("beat_last", int'(out_last), int'(e.last));
          ones += int'(out_bit);
          if (e.last) begin
            check("frame_ones", ones, ones_q.pop_front());
            ones = 0;
          end
        end
      end
    end
  end

  // Downstream ready: always asserted or pseudo-random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_random ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic send(input int cnt, input bit md);
    bit got;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_count = CB'(cnt);
    in_mode  = md;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("latency_valid", int'(out_valid), 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!out_valid && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_timeout", int'(done), 1);
  endtask

  task automatic back_to_back();
    int run;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_count = CB'(5);
    in_mode  = 1'b0;
    @(negedge clk);
    check("b2b_idle_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_count = CB'(2);
    run = 0;
    for (int c = 0; c < FB; c++) begin
      @(negedge clk);
      check("b2b_in_ready", int'(in_ready), (c == FB - 1) ? 1 : 0);
      if (out_valid) run++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3 * FB; c++) begin
      @(negedge clk);
      if (!out_valid) break;
      run++;
    end
    check("b2b_run_len", run, 2 * FB);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_bit", int'(out_bit), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed frames, downstream always ready.
    send(3, 1'b0);
    wait_idle();
    send(3, 1'b1);
    wait_idle();
    check("spread_acc_zero", int'(dut.acc), 0);
    send(0, 1'b0);
    send(0, 1'b1);
    send(15, 1'b0);
    send(15, 1'b1);
    wait_idle();

    // Backpressure on a spread frame.
    rdy_random = 1'b1;
    send(5, 1'b1);
    wait_idle();
    rdy_random = 1'b0;

    back_to_back();
    wait_idle();

    // Asynchronous reset in the middle of a frame.
    send(8, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_last", int'(out_last), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    ones_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_in_ready", int'(in_ready), 1);
    send(1, 1'b0);
    wait_idle();

    // Randomized requests, random stalls and gaps.
    rdy_random = 1'b1;
    for (int k = 0; k < 30; k++) begin
      send(int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    rdy_random = 1'b0;

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
